sram_responder: RTL

Synchronous, clocked responder for the asynchronous-SRAM pin bus (`A`, `DQ`, `nCE`, `nOE`, `nWE`) driven by the SRAM controller. It plays the memory side of that bus from on-chip block RAM, letting the controller, checker and UART tester run without the SDRAM-backed SRAM wrapper. It also acts as a bus monitor: it counts completed reads and writes and flags illegal pin combinations. Tri-state merging of `DQ` stays in the top level.

---
 rtl/sram_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Memory-side responder for the asynchronous-SRAM pin bus, backed by on-chip RAM.
// Also monitors the bus: counts committed writes / delivered reads and flags nCE/nOE/nWE all low.
module sram_responder #(
    parameter int unsigned ADDR_WIDTH   = 21,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MEM_DEPTH    = 4096,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic                  sram_nce,
    input  logic                  sram_noe,
    input  logic                  sram_nwe,
    output logic                  data_valid,
    output logic                  bus_conflict,
    output logic [15:0]           write_count,
    output logic [15:0]           read_count
);

    localparam int unsigned WORD_W = $clog2(MEM_DEPTH);
    localparam int unsigned LAT_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_prev_q;
    logic [DATA_WIDTH-1:0] dq_q;
    logic                  nce_q;
    logic                  noe_q;
    logic                  nwe_q;

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     pend_word_q, pend_word_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
    logic                  oe_q, oe_d;
    logic                  valid_q, valid_d;
    logic                  conflict_q, conflict_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic [CNT_W-1:0]      rcnt_q, rcnt_d;

    logic                  wr_req_c;
    logic                  rd_req_c;
    logic                  conflict_c;
    logic                  addr_chg_c;
    logic                  commit_c;
    logic [LAT_W-1:0]      lat_eff_c;
    logic [WORD_W-1:0]     word_c;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Single register stage on every bus pin; all decisions use these copies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            addr_prev_q <= '0;
            dq_q        <= '0;
            nce_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
        end else begin
            addr_q      <= sram_addr;
            addr_prev_q <= addr_q;
            dq_q        <= sram_dq_in;
            nce_q       <= sram_nce;
            noe_q       <= sram_noe;
            nwe_q       <= sram_nwe;
        end
    end

    // A conflict (all three low) is treated as a write.
    assign wr_req_c   = !nce_q && !nwe_q;
    assign rd_req_c   = !nce_q && !noe_q && nwe_q;
    assign conflict_c = !nce_q && !noe_q && !nwe_q;
    assign addr_chg_c = (addr_q != addr_prev_q);
    assign word_c     = addr_q[WORD_W-1:0];
    // An address change restarts the countdown in the same cycle it is seen.
    assign lat_eff_c  = addr_chg_c ? LAT_LOAD : lat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_req_c) begin
                    state_d = ST_WRITE;
                end else if (rd_req_c) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (!wr_req_c) begin
                    state_d = rd_req_c ? ST_READ : ST_IDLE;
                end
            end
            ST_READ: begin
                if (wr_req_c) begin
                    state_d = ST_WRITE;
                end else if (nce_q || noe_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_word_d = pend_word_q;
        pend_data_d = pend_data_q;
        lat_d       = lat_q;
        dq_out_d    = dq_out_q;
        valid_d     = 1'b0;
        oe_d        = (state_d == ST_READ);
        conflict_d  = conflict_q || conflict_c;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        commit_c    = 1'b0;

        // Pending registers track the last cycle with the write strobe low.
        if (wr_req_c) begin
            pend_word_d = word_c;
            pend_data_d = dq_q;
        end

        case (state_q)
            ST_WRITE: begin
                if (!wr_req_c) begin
                    commit_c = 1'b1;
                    wcnt_d   = wcnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (state_d == ST_READ) begin
                    if (lat_eff_c == '0) begin
                        dq_out_d = mem[word_c];
                        valid_d  = 1'b1;
                        if (!valid_q || addr_chg_c) begin
                            rcnt_d = rcnt_q + CNT_W'(1);
                        end
                    end else begin
                        lat_d = lat_eff_c - LAT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if ((state_q != ST_READ) && (state_d == ST_READ)) begin
            lat_d = LAT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_word_q <= '0;
            pend_data_q <= '0;
            lat_q       <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            valid_q     <= 1'b0;
            conflict_q  <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
        end else begin
            pend_word_q <= pend_word_d;
            pend_data_q <= pend_data_d;
            lat_q       <= lat_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            valid_q     <= valid_d;
            conflict_q  <= conflict_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[pend_word_q] <= pend_data_q;
        end
    end

    assign sram_dq_out  = dq_out_q;
    assign sram_dq_oe   = oe_q;
    assign data_valid   = valid_q;
    assign bus_conflict = conflict_q;
    assign write_count  = wcnt_q;
    assign read_count   = rcnt_q;

endmodule
